// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: valid/ready handshake with a one-entry skid buffer,
// registered in_ready, synchronous flush and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam int PAY_W = 2 * DATA_W + RD_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PAY_W-1:0]   main_q, main_d;
  logic [PAY_W-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   bubble_q, bubble_d;

  logic [PAY_W-1:0]   in_payload;
  logic               fire_in;
  logic               fire_out;
  logic               bubble_inc;

  assign in_payload = {in_data_1, in_data_2, in_rd};
  assign fire_in    = in_valid & in_ready_q;
  assign fire_out   = out_valid & out_ready;

  // State register
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      bubble_q   <= bubble_d;
    end
  end

  // Next-state and datapath steering
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (fire_in) begin
          state_d = ST_ONE;
          main_d  = in_payload;
        end
      end
      ST_ONE: begin
        if (fire_in && fire_out) begin
          main_d = in_payload;
        end else if (fire_in) begin
          state_d = ST_FULL;
          skid_d  = in_payload;
        end else if (fire_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Skid entry is always younger than main, so it only ever refills main.
        if (out_ready) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush squashes occupancy and any same-cycle input; data regs keep contents.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // in_ready is a pure function of the next state so it can be registered.
  always_comb begin
    in_ready_d = (state_d != ST_FULL);
  end

  assign bubble_inc = out_ready & ~out_valid & ~flush;

  always_comb begin
    bubble_d = bubble_q;
    if (bubble_inc && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  // Output process
  always_comb begin
    out_valid    = (state_q != ST_EMPTY);
    in_ready     = in_ready_q;
    out_data_1   = main_q[PAY_W-1 -: DATA_W];
    out_data_2   = main_q[RD_W +: DATA_W];
    out_rd       = main_q[RD_W-1:0];
    bubble_count = bubble_q;
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (CNT_W=2 to reach saturation quickly).
module tb_id_ex_pipe_reg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CNT_W  = 2;

  logic              CLOCK;
  logic              RESET;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data_1;
  logic [DATA_W-1:0] in_data_2;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data_1;
  logic [DATA_W-1:0] out_data_2;
  logic [RD_W-1:0]   out_rd;
  logic [CNT_W-1:0]  bubble_count;

  int checks_q = 0;
  int errors_q = 0;

  id_ex_pipe_reg #(
    .DATA_W(DATA_W),
    .RD_W  (RD_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data_1   (in_data_1),
    .in_data_2   (in_data_2),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data_1  (out_data_1),
    .out_data_2  (out_data_2),
    .out_rd      (out_rd),
    .bubble_count(bubble_count)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_q++;
    if (obs !== exp) begin
      errors_q++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one edge; inputs are updated after this returns, outputs are sampled 1ns past the edge.
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic offer(input logic v, input logic [DATA_W-1:0] d1,
                       input logic [DATA_W-1:0] d2, input logic [RD_W-1:0] rd);
    in_valid  = v;
    in_data_1 = d1;
    in_data_2 = d2;
    in_rd     = rd;
  endtask

  initial begin
    RESET     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    offer(1'b0, '0, '0, '0);

    // Reset
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_rd",    64'(out_rd), 64'd0);
    check("rst_out_d1",    64'(out_data_1), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_count",     64'(bubble_count), 64'd0);
    RESET = 1'b0;

    // Streaming back-to-back
    out_ready = 1'b1;
    offer(1'b1, 32'h11, 32'h22, 5'd3);
    step();
    check("s1_valid", 64'(out_valid), 64'd1);
    check("s1_d1",    64'(out_data_1), 64'h11);
    check("s1_d2",    64'(out_data_2), 64'h22);
    check("s1_rd",    64'(out_rd), 64'd3);
    check("s1_rdy",   64'(in_ready), 64'd1);
    offer(1'b1, 32'h33, 32'h44, 5'd7);
    step();
    check("s2_d1",    64'(out_data_1), 64'h33);
    check("s2_d2",    64'(out_data_2), 64'h44);
    check("s2_rd",    64'(out_rd), 64'd7);
    check("s2_rdy",   64'(in_ready), 64'd1);
    offer(1'b0, '0, '0, '0);
    step();
    check("s3_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: A then B with out_ready low
    out_ready = 1'b0;
    offer(1'b1, 32'hA1, 32'hA2, 5'd9);
    step();
    check("bp_a_rd",  64'(out_rd), 64'd9);
    check("bp_a_rdy", 64'(in_ready), 64'd1);
    offer(1'b1, 32'hB1, 32'hB2, 5'd10);
    step();
    check("bp_full_rdy", 64'(in_ready), 64'd0);
    check("bp_full_rd",  64'(out_rd), 64'd9);
    offer(1'b1, 32'hEE, 32'hEE, 5'd31);
    step();
    check("bp_stall_d1",  64'(out_data_1), 64'hA1);
    check("bp_stall_rdy", 64'(in_ready), 64'd0);
    offer(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    check("bp_a_out_valid", 64'(out_valid), 64'd1);
    step();
    check("bp_b_rd",  64'(out_rd), 64'd10);
    check("bp_b_d2",  64'(out_data_2), 64'hB2);
    check("bp_b_rdy", 64'(in_ready), 64'd1);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with C offered
    out_ready = 1'b0;
    offer(1'b1, 32'hA1, 32'hA2, 5'd9);
    step();
    offer(1'b1, 32'hB1, 32'hB2, 5'd10);
    step();
    check("fl_pre_rdy", 64'(in_ready), 64'd0);
    offer(1'b1, 32'hC1, 32'hC2, 5'd12);
    flush = 1'b1;
    step();
    check("fl_valid",  64'(out_valid), 64'd0);
    check("fl_rdy",    64'(in_ready), 64'd1);
    check("fl_hold_rd", 64'(out_rd), 64'd9);
    flush = 1'b0;
    offer(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fl_post_valid%0d", i), 64'(out_valid), 64'd0);
    end

    // Bubble counter saturation
    RESET = 1'b1;
    step();
    check("bub_rst", 64'(bubble_count), 64'd0);
    RESET = 1'b0;
    flush = 1'b1;
    step();
    check("bub_flush_no_inc", 64'(bubble_count), 64'd0);
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("bub_cyc%0d", i + 1), 64'(bubble_count), (i < 3) ? 64'(i + 1) : 64'd3);
    end

    // RESET together with flush while FULL
    out_ready = 1'b0;
    offer(1'b1, 32'h51, 32'h52, 5'd17);
    step();
    offer(1'b1, 32'h61, 32'h62, 5'd18);
    step();
    check("r6_pre_rdy", 64'(in_ready), 64'd0);
    offer(1'b1, 32'h71, 32'h72, 5'd19);
    RESET = 1'b1;
    flush = 1'b1;
    step();
    check("r6_valid", 64'(out_valid), 64'd0);
    check("r6_d1",    64'(out_data_1), 64'd0);
    check("r6_d2",    64'(out_data_2), 64'd0);
    check("r6_rd",    64'(out_rd), 64'd0);
    check("r6_rdy",   64'(in_ready), 64'd1);
    check("r6_count", 64'(bubble_count), 64'd0);
    RESET = 1'b0;
    flush = 1'b0;
    offer(1'b0, '0, '0, '0);
    step();
    check("r6_no_pulse", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
